regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Integer register file for the RISC-V core.
- Combines the write-side decoder (one write bus steered to one of NREGS registers) with the read-side operand selection.
- A per-register pending-write scoreboard raises `stall` for RAW/WAW hazards between issue and writeback.
- Sits between decode/issue (read ports, issue) and writeback (write port).

Parameters:
- XLEN, 32, data width of each register and port.
- NREGS, 32, number of architectural registers; register 0 is hardwired zero.
- AW, 5, address width; must satisfy 2^AW == NREGS.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- rs1_addr  input  AW  source 1 register index
- rs1_used  input  1  instruction reads rs1; enables hazard check
- rs2_addr  input  AW  source 2 register index
- rs2_used  input  1  instruction reads rs2; enables hazard check
- rs1_data  output  XLEN  source 1 operand, combinational
- rs2_data  output  XLEN  source 2 operand, combinational
- issue_en  input  1  decode requests to issue an instruction
- issue_rd_valid  input  1  issuing instruction writes a destination
- issue_rd  input  AW  destination index of the issuing instruction
- issue_ack  output  1  issue accepted this cycle (issue_en && !stall)
- stall  output  1  hazard present; decode must hold
- wr_en  input  1  writeback valid
- wr_addr  input  AW  writeback register index
- wr_data  input  XLEN  writeback data
- pending  output  NREGS  scoreboard bit vector (debug/verification)

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, pending = 0. During reset, rs*_data reflect zeroed registers; stall = 0; issue_ack = 0 (forced low while rst_n low).
- Writes: on posedge clk with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data. wr_addr==0 is ignored; no state change.
- Reads (combinational):
  - addr==0 -> 0.
  - else if wr_en && wr_addr==addr -> wr_data (write-through bypass).
  - else reg[addr].
  - Applies independently to both ports; both ports may read the same register.
- Effective pending for a read or issue check, eff(r) = pending[r] && !(wr_en && wr_addr==r). A same-cycle writeback resolves the hazard.
- stall = issue_en && (
  - (rs1_used && rs1_addr!=0 && eff(rs1_addr)) or
  - (rs2_used && rs2_addr!=0 && eff(rs2_addr)) or
  - (issue_rd_valid && issue_rd!=0 && eff(issue_rd)) [WAW]
  ).
- stall is 0 when issue_en=0.
- issue_ack = issue_en && !stall.
- Scoreboard update at posedge, per register r!=0:
  - set if issue_ack && issue_rd_valid && issue_rd==r.
  - else clear if wr_en && wr_addr==r.
  - Set has priority over clear when both target r in the same cycle; the new producer is outstanding.
- pending[0] is always 0; issue_rd==0 never sets it.
- A writeback to a non-pending register still updates the data; no error is raised.
- Only one outstanding write per register is allowed; WAW stall enforces this.
- Latency:
  - Write visible on read ports in the same cycle via bypass, and from the register thereafter.
  - Pending set is visible to stall starting the cycle after issue.
- Reset mid-operation clears all pending bits and data immediately; in-flight writebacks after reset release are simply written.

Test Plan:
- Reset, then read all 32 addresses -> all rs*_data = 0, pending = 0, stall = 0.
- Write x5=0xDEADBEEF with rs1_addr=5 in the same cycle -> rs1_data=0xDEADBEEF combinationally. Next cycle, with wr_en=0 -> still 0xDEADBEEF. Write x0=0x1234 -> x0 reads 0.
- Issue rd=7 (ack=1); next cycle issue with rs2_addr=7, rs2_used=1 -> stall=1, issue_ack=0. Assert wr_en to x7 with 0x55 in that cycle -> stall=0, rs2_data=0x55, pending[7] clears.
- Issue rd=3 while wr_en to x3 in the same cycle, with x3 previously pending from an earlier issue -> pending[3] remains 1. A second issue to rd=3 with no writeback -> stall=1 (WAW).
- Hazard-masking cases, with x9 pending:
  - rs1_used=0, rs1_addr=9 -> stall=0.
  - issue_en=0 -> stall=0.
  - rs1_addr=0 -> never stalls.
- Pending x4 and x6, then drop rst_n asynchronously mid-cycle -> pending=0 and x4/x6 read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Purpose: integer register file with write-through read ports and a pending-write scoreboard.
// Latency: reads are combinational (same-cycle bypass of writeback); pending bits set one cycle after issue.
// Backpressure: stall holds decode on RAW/WAW hazards; issue_ack marks an accepted issue.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   rs1_addr/rs1_used, rs2_addr/... source operand indices and "is read" qualifiers
//   rs1_data, rs2_data              combinational operands (x0 reads zero, writeback bypassed)
//   issue_en, issue_rd_valid,
//   issue_rd                        issue request and its destination
//   issue_ack, stall                issue accepted / hazard present
//   wr_en, wr_addr, wr_data         writeback port
//   pending                         scoreboard vector, one bit per register
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     rs1_addr,
  input  logic              rs1_used,
  input  logic [AW-1:0]     rs2_addr,
  input  logic              rs2_used,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  input  logic              issue_en,
  input  logic              issue_rd_valid,
  input  logic [AW-1:0]     issue_rd,
  output logic              issue_ack,
  output logic              stall,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  output logic [NREGS-1:0]  pending
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] eff_pend;
  logic             haz_rs1;
  logic             haz_rs2;
  logic             haz_rd;

  // One-hot of the register being written back this cycle.
  assign wr_hit = wr_en ? (NREGS'(1) << wr_addr) : '0;

  // A writeback landing this cycle resolves the hazard on that register.
  assign eff_pend = pending & ~wr_hit;

  // Read ports: x0 is zero, then writeback bypass, then the array.
  always_comb begin
    rs1_data = regs[rs1_addr];
    if (rs1_addr == '0)
      rs1_data = '0;
    else if (wr_en && (wr_addr == rs1_addr))
      rs1_data = wr_data;
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
    if (rs2_addr == '0)
      rs2_data = '0;
    else if (wr_en && (wr_addr == rs2_addr))
      rs2_data = wr_data;
  end

  assign haz_rs1 = rs1_used && (rs1_addr != '0) && eff_pend[rs1_addr];
  assign haz_rs2 = rs2_used && (rs2_addr != '0) && eff_pend[rs2_addr];
  // WAW: only one outstanding producer per register.
  assign haz_rd  = issue_rd_valid && (issue_rd != '0) && eff_pend[issue_rd];

  assign stall     = issue_en && (haz_rs1 || haz_rs2 || haz_rd);
  // Gated by rst_n so no issue is accepted while the scoreboard is held clear.
  assign issue_ack = rst_n && issue_en && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Set beats clear: a new producer issued in the same cycle the old one
  // writes back is still outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending[0] <= 1'b0;
      for (int r = 1; r < NREGS; r++) begin
        if (issue_ack && issue_rd_valid && (issue_rd == AW'(r)))
          pending[r] <= 1'b1;
        else if (wr_en && (wr_addr == AW'(r)))
          pending[r] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Purpose: directed self-checking bench for regfile_scoreboard.
// Latency: inputs driven 1ns after posedge, combinational outputs checked 1ns later.
// Backpressure: stall/issue_ack checked against hand-computed hazard expectations.
module tb_regfile_scoreboard;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [AW-1:0]    rs1_addr, rs2_addr, issue_rd, wr_addr;
  logic             rs1_used, rs2_used, issue_en, issue_rd_valid, wr_en;
  logic [XLEN-1:0]  rs1_data, rs2_data, wr_data;
  logic             issue_ack, stall;
  logic [NREGS-1:0] pending;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs1_used(rs1_used),
    .rs2_addr(rs2_addr), .rs2_used(rs2_used),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_en(issue_en), .issue_rd_valid(issue_rd_valid), .issue_rd(issue_rd),
    .issue_ack(issue_ack), .stall(stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pending(pending)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rs1_addr = '0; rs1_used = 1'b0; rs2_addr = '0; rs2_used = 1'b0;
    issue_en = 1'b0; issue_rd_valid = 1'b0; issue_rd = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    idle();
    issue_en = 1'b1; issue_rd_valid = 1'b1; issue_rd = rd;
    #1 chk("issue_ack", issue_ack, 1'b1);
    step();
    idle();
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    idle();
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    // Reset state: every address reads zero on both ports.
    for (int i = 0; i < NREGS; i++) begin
      rs1_addr = AW'(i); rs2_addr = AW'(NREGS - 1 - i);
      #1;
      chk("rst_rs1", rs1_data, 0);
      chk("rst_rs2", rs2_data, 0);
    end
    chk("rst_pending", pending, 0);
    chk("rst_stall", stall, 0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Write-through bypass, then value from the array.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rs1_addr = 5'd5;
    #1 chk("bypass_x5", rs1_data, 32'hDEADBEEF);
    step();
    wr_en = 1'b0;
    #1 chk("reg_x5", rs1_data, 32'hDEADBEEF);
    // Write to x0 ignored.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1 chk("x0_bypass", rs1_data, 0);
    step();
    wr_en = 1'b0;
    #1 chk("x0_after", rs2_data, 0);
    chk("x0_pending", pending, 0);
    idle();

    // RAW on x7, resolved by same-cycle writeback.
    issue(5'd7);
    chk("pend7_set", pending, 32'h0000_0080);
    issue_en = 1'b1; rs2_addr = 5'd7; rs2_used = 1'b1;
    #1 chk("raw7_stall", stall, 1'b1);
    chk("raw7_ack", issue_ack, 1'b0);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
    #1 chk("raw7_wb_stall", stall, 1'b0);
    chk("raw7_wb_ack", issue_ack, 1'b1);
    chk("raw7_bypass", rs2_data, 32'h55);
    step();
    idle();
    rs2_addr = 5'd7;
    #1 chk("pend7_clr", pending, 0);
    chk("reg_x7", rs2_data, 32'h55);

    // Set beats clear on x3; second issue hits WAW.
    issue(5'd3);
    chk("pend3_set", pending, 32'h0000_0008);
    issue_en = 1'b1; issue_rd_valid = 1'b1; issue_rd = 5'd3;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    #1 chk("x3_wb_issue_ack", issue_ack, 1'b1);
    step();
    wr_en = 1'b0;
    #1 chk("pend3_kept", pending, 32'h0000_0008);
    chk("waw3_stall", stall, 1'b1);
    chk("waw3_ack", issue_ack, 1'b0);
    write(5'd3, 32'h34);
    chk("pend3_clr", pending, 0);

    // Hazard masking with x9 pending.
    issue(5'd9);
    issue_en = 1'b1; rs1_addr = 5'd9; rs1_used = 1'b0;
    #1 chk("mask_unused", stall, 1'b0);
    rs1_used = 1'b1;
    #1 chk("raw9_stall", stall, 1'b1);
    issue_en = 1'b0;
    #1 chk("mask_noissue", stall, 1'b0);
    chk("noissue_ack", issue_ack, 1'b0);
    issue_en = 1'b1; rs1_addr = 5'd0;
    #1 chk("mask_x0", stall, 1'b0);
    issue_rd_valid = 1'b1; issue_rd = 5'd0;
    #1 chk("rd0_ack", issue_ack, 1'b1);
    step();
    idle();
    #1 chk("rd0_no_pend", pending, 32'h0000_0200);

    // Async reset mid-cycle with x4/x6 holding data and pending.
    write(5'd4, 32'h44);
    write(5'd6, 32'h66);
    issue(5'd4);
    issue(5'd6);
    rs1_addr = 5'd4; rs2_addr = 5'd6;
    #1 chk("pend_469", pending, 32'h0000_0250);
    chk("pre_rst_x4", rs1_data, 32'h44);
    chk("pre_rst_x6", rs2_data, 32'h66);
    issue_en = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk("arst_pending", pending, 0);
    chk("arst_x4", rs1_data, 0);
    chk("arst_x6", rs2_data, 0);
    chk("arst_stall", stall, 0);
    chk("arst_ack", issue_ack, 0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    // Late writeback after reset release is simply written.
    write(5'd4, 32'h77);
    rs1_addr = 5'd4;
    #1 chk("post_rst_x4", rs1_data, 32'h77);
    chk("post_rst_pending", pending, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
